// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/retire, NUM_CDB result ports and selective squash.
// Results are committable one cycle after their CDB broadcast; alloc_ready drops while full or flushing.
module rob_param #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int XLEN    = 32,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [4:0]               alloc_dest,
  input  logic                     alloc_writes,
  input  logic                     alloc_is_branch,
  input  logic                     alloc_is_store,
  input  logic                     alloc_pred_taken,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  input  logic [NUM_CDB-1:0]       cdb_taken,
  input  logic                     flush_valid,
  input  logic [TAG_W-1:0]         flush_tag,
  input  logic                     commit_ready,
  output logic                     commit_valid,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [4:0]               commit_dest,
  output logic                     commit_writes,
  output logic [XLEN-1:0]          commit_value,
  output logic [XLEN-1:0]          commit_pc,
  output logic                     commit_is_branch,
  output logic                     commit_is_store,
  output logic                     commit_mispredict,
  output logic                     head_store,
  output logic [TAG_W:0]           count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [TAG_W:0] PTR_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]      dest;
    logic            writes;
    logic            is_branch;
    logic            is_store;
    logic            pred_taken;
    logic            taken;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t            ent [DEPTH];
  logic [DEPTH-1:0]  vld_q, rdy_q;
  logic [TAG_W:0]    head_ptr, tail_ptr;
  logic [TAG_W-1:0]  head_idx, tail_idx, flush_age;
  logic              alloc_fire, commit_fire, flush_hit;
  logic [DEPTH-1:0]  squash, cdb_match, cdb_hit, cdb_tkn;
  logic [XLEN-1:0]   cdb_val [DEPTH];

  assign head_idx    = head_ptr[TAG_W-1:0];
  assign tail_idx    = tail_ptr[TAG_W-1:0];
  assign count       = tail_ptr - head_ptr;
  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign alloc_ready = !full && !flush_valid;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign flush_hit   = flush_valid && vld_q[flush_tag];
  assign flush_age   = flush_tag - head_idx;

  assign commit_valid      = vld_q[head_idx] && rdy_q[head_idx];
  assign commit_fire       = commit_valid && commit_ready;
  assign commit_tag        = head_idx;
  assign commit_dest       = ent[head_idx].dest;
  assign commit_writes     = ent[head_idx].writes;
  assign commit_value      = ent[head_idx].value;
  assign commit_pc         = ent[head_idx].pc;
  assign commit_is_branch  = ent[head_idx].is_branch;
  assign commit_is_store   = ent[head_idx].is_store;
  assign commit_mispredict = commit_valid && ent[head_idx].is_branch &&
                             (ent[head_idx].taken != ent[head_idx].pred_taken);
  assign head_store        = vld_q[head_idx] && ent[head_idx].is_store;

  // Ports scanned high to low so the lowest-index port carrying a tag wins.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      squash[e]    = flush_hit && ((TAG_W'(e) - head_idx) > flush_age);
      cdb_match[e] = 1'b0;
      cdb_val[e]   = '0;
      cdb_tkn[e]   = 1'b0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e))) begin
          cdb_match[e] = 1'b1;
          cdb_val[e]   = cdb_value[i*XLEN +: XLEN];
          cdb_tkn[e]   = cdb_taken[i];
        end
      end
      cdb_hit[e] = cdb_match[e] && vld_q[e] && !rdy_q[e] && !squash[e];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      vld_q    <= '0;
      rdy_q    <= '0;
    end else begin
      if (commit_fire) head_ptr <= head_ptr + PTR_ONE;
      // The branch at flush_tag survives; everything younger is dropped.
      if (flush_hit)       tail_ptr <= head_ptr + {1'b0, flush_age} + PTR_ONE;
      else if (alloc_fire) tail_ptr <= tail_ptr + PTR_ONE;
      for (int e = 0; e < DEPTH; e++) begin
        if (alloc_fire && (tail_idx == TAG_W'(e))) begin
          vld_q[e] <= 1'b1;
          rdy_q[e] <= 1'b0;
        end else if (squash[e] || (commit_fire && (head_idx == TAG_W'(e)))) begin
          vld_q[e] <= 1'b0;
          rdy_q[e] <= 1'b0;
        end else if (cdb_hit[e]) begin
          rdy_q[e] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (alloc_fire && (tail_idx == TAG_W'(e))) begin
        ent[e].dest       <= alloc_dest;
        ent[e].writes     <= alloc_writes;
        ent[e].is_branch  <= alloc_is_branch;
        ent[e].is_store   <= alloc_is_store;
        ent[e].pred_taken <= alloc_pred_taken;
        ent[e].taken      <= 1'b0;
        ent[e].value      <= '0;
        ent[e].pc         <= alloc_pc;
      end else if (cdb_hit[e]) begin
        ent[e].value <= cdb_val[e];
        ent[e].taken <= cdb_tkn[e];
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: vector table plus directed sequences, commit stream checked against a scoreboard.
module tb_rob_param;
  localparam int DEPTH = 16, NUM_CDB = 2, XLEN = 32, TAG_W = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     alloc_valid, alloc_ready;
  logic [TAG_W-1:0]         alloc_tag;
  logic [4:0]               alloc_dest;
  logic                     alloc_writes, alloc_is_branch, alloc_is_store, alloc_pred_taken;
  logic [XLEN-1:0]          alloc_pc;
  logic [NUM_CDB-1:0]       cdb_valid, cdb_taken;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_value;
  logic                     flush_valid;
  logic [TAG_W-1:0]         flush_tag;
  logic                     commit_ready, commit_valid;
  logic [TAG_W-1:0]         commit_tag;
  logic [4:0]               commit_dest;
  logic                     commit_writes;
  logic [XLEN-1:0]          commit_value, commit_pc;
  logic                     commit_is_branch, commit_is_store, commit_mispredict, head_store;
  logic [TAG_W:0]           count;
  logic                     full, empty;

  always #5 clk = ~clk;

  rob_param #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_dest(alloc_dest), .alloc_writes(alloc_writes), .alloc_is_branch(alloc_is_branch),
    .alloc_is_store(alloc_is_store), .alloc_pred_taken(alloc_pred_taken), .alloc_pc(alloc_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_dest(commit_dest), .commit_writes(commit_writes), .commit_value(commit_value),
    .commit_pc(commit_pc), .commit_is_branch(commit_is_branch), .commit_is_store(commit_is_store),
    .commit_mispredict(commit_mispredict), .head_store(head_store),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  pc;
  } sb_t;

  typedef struct {
    logic             av;
    logic             cv;
    logic [TAG_W-1:0] ct;
    logic [XLEN-1:0]  cval;
    logic             cr;
    int               ecount;
    logic             ecv;
    int               etag;
  } vec_t;

  sb_t            sb[$];
  logic [XLEN-1:0] val_m [DEPTH];
  int             total = 0;
  int             bad = 0;
  int             tail_m = 0;
  vec_t           vt [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    cdb_valid   = '0;
    flush_valid = 1'b0;
  endtask

  task automatic alloc_set(input logic st, input logic br, input logic pt);
    logic [XLEN-1:0] pc;
    pc = 32'h1000 + 32'(4 * tail_m);
    chk("alloc_tag", 64'(alloc_tag), 64'(tail_m % DEPTH));
    alloc_valid      = 1'b1;
    alloc_dest       = 5'(tail_m + 1);
    alloc_writes     = 1'b1;
    alloc_is_store   = st;
    alloc_is_branch  = br;
    alloc_pred_taken = pt;
    alloc_pc         = pc;
    sb.push_back('{tag: TAG_W'(tail_m % DEPTH), pc: pc});
    tail_m++;
  endtask

  task automatic cdb_set(input int port, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val,
                         input logic tk, input logic upd);
    cdb_valid[port]               = 1'b1;
    cdb_tag[port*TAG_W +: TAG_W]  = tag;
    cdb_value[port*XLEN +: XLEN]  = val;
    cdb_taken[port]               = tk;
    if (upd) val_m[tag] = val;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    alloc_valid  = 1'b0;
    cdb_valid    = '0;
    flush_valid  = 1'b0;
    commit_ready = 1'b0;
    tick();
    sb.delete();
    tail_m = 0;
    reset  = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (reset && commit_valid && commit_ready) begin
      chk("sb_has_entry", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        chk("commit_tag", 64'(commit_tag), 64'(e.tag));
        chk("commit_pc", 64'(commit_pc), 64'(e.pc));
        chk("commit_value", 64'(commit_value), 64'(val_m[e.tag]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    alloc_dest = '0; alloc_writes = 0; alloc_is_branch = 0; alloc_is_store = 0;
    alloc_pred_taken = 0; alloc_pc = '0; cdb_tag = '0; cdb_value = '0; cdb_taken = '0;
    flush_tag = '0;
    for (int i = 0; i < DEPTH; i++) val_m[i] = '0;

    //        av  cv  ct  cval        cr  cnt cv  tag
    vt[0]  = '{1, 0, 0, 32'h0,      0, 1, 0, 1};
    vt[1]  = '{1, 0, 0, 32'h0,      0, 2, 0, 2};
    vt[2]  = '{1, 0, 0, 32'h0,      0, 3, 0, 3};
    vt[3]  = '{0, 1, 1, 32'hA1,     0, 3, 0, 3};
    vt[4]  = '{0, 1, 0, 32'hA0,     0, 3, 1, 3};
    vt[5]  = '{1, 0, 0, 32'h0,      1, 3, 1, 4};
    vt[6]  = '{0, 0, 0, 32'h0,      1, 2, 0, 4};
    vt[7]  = '{0, 1, 2, 32'hA2,     1, 2, 1, 4};
    vt[8]  = '{0, 0, 0, 32'h0,      1, 1, 0, 4};
    vt[9]  = '{0, 1, 3, 32'hA3,     0, 1, 1, 4};
    vt[10] = '{0, 0, 0, 32'h0,      1, 0, 0, 4};

    do_reset();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_head_store", 64'(head_store), 64'(0));
    chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));

    for (int r = 0; r < 11; r++) begin
      if (vt[r].av) alloc_set(1'b0, 1'b0, 1'b0);
      if (vt[r].cv) cdb_set(0, vt[r].ct, vt[r].cval, 1'b0, 1'b1);
      commit_ready = vt[r].cr;
      tick();
      chk($sformatf("vec%0d_count", r), 64'(count), 64'(vt[r].ecount));
      chk($sformatf("vec%0d_cvld", r), 64'(commit_valid), 64'(vt[r].ecv));
      chk($sformatf("vec%0d_atag", r), 64'(alloc_tag), 64'(vt[r].etag));
    end
    commit_ready = 1'b0;

    // Reset while holding five entries.
    do_reset();
    for (int i = 0; i < 5; i++) begin alloc_set(1'b0, 1'b0, 1'b0); tick(); end
    chk("mid_count5", 64'(count), 64'(5));
    reset = 1'b0;
    tick();
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_empty", 64'(empty), 64'(1));
    chk("mid_rst_cvld", 64'(commit_valid), 64'(0));
    chk("mid_rst_atag", 64'(alloc_tag), 64'(0));
    sb.delete(); tail_m = 0;
    reset = 1'b1;
    tick();

    // Fill to DEPTH, retire the head, tail index wraps.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin alloc_set(1'b0, 1'b0, 1'b0); tick(); end
    chk("full_flag", 64'(full), 64'(1));
    chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
    chk("full_count", 64'(count), 64'(16));
    alloc_valid = 1'b1;
    cdb_set(0, 0, 32'hDEAD, 1'b0, 1'b1);
    tick();
    chk("full_count_hold", 64'(count), 64'(16));
    chk("full_cvld", 64'(commit_valid), 64'(1));
    chk("full_cvalue", 64'(commit_value), 64'(32'hDEAD));
    commit_ready = 1'b1;
    alloc_valid  = 1'b1;
    chk("full_nobypass", 64'(alloc_ready), 64'(0));
    tick();
    commit_ready = 1'b0;
    chk("wrap_count", 64'(count), 64'(15));
    chk("wrap_full", 64'(full), 64'(0));
    chk("wrap_atag", 64'(alloc_tag), 64'(0));

    // Two ports, out-of-order completion, same-tag priority.
    do_reset();
    for (int i = 0; i < 4; i++) begin alloc_set(1'b0, 1'b0, 1'b0); tick(); end
    cdb_set(0, 3, 32'h33, 1'b0, 1'b1);
    cdb_set(1, 1, 32'h31, 1'b0, 1'b1);
    commit_ready = 1'b1;
    tick();
    chk("ooo_head_wait", 64'(commit_valid), 64'(0));
    cdb_set(0, 0, 32'h30, 1'b0, 1'b1);
    tick();
    chk("ooo_tag0", 64'(commit_tag), 64'(0));
    chk("ooo_cvld0", 64'(commit_valid), 64'(1));
    tick();
    chk("ooo_tag1", 64'(commit_tag), 64'(1));
    tick();
    chk("ooo_head2_wait", 64'(commit_valid), 64'(0));
    cdb_set(1, 2, 32'h22, 1'b0, 1'b0);
    cdb_set(0, 2, 32'h11, 1'b0, 1'b0);
    val_m[2] = 32'h11;
    tick();
    chk("prio_value", 64'(commit_value), 64'(32'h11));
    tick();
    tick();
    chk("ooo_drained", 64'(count), 64'(0));
    commit_ready = 1'b0;

    // Selective squash.
    do_reset();
    for (int i = 0; i < 8; i++) begin alloc_set(1'b0, 1'b0, 1'b0); tick(); end
    flush_valid = 1'b1;
    flush_tag   = 4;
    alloc_valid = 1'b1;
    #1;
    chk("flush_alloc_ready", 64'(alloc_ready), 64'(0));
    tick();
    chk("flush_count", 64'(count), 64'(5));
    chk("flush_atag", 64'(alloc_tag), 64'(5));
    repeat (3) void'(sb.pop_back());
    tail_m = 5;
    cdb_set(0, 6, 32'h66, 1'b0, 1'b0);
    cdb_set(1, 5, 32'h55, 1'b0, 1'b0);
    tick();
    chk("flush_count_hold", 64'(count), 64'(5));
    for (int t = 0; t < 5; t++) begin cdb_set(0, TAG_W'(t), 32'h40 + 32'(t), 1'b0, 1'b1); tick(); end
    commit_ready = 1'b1;
    repeat (6) tick();
    commit_ready = 1'b0;
    chk("squash_empty", 64'(empty), 64'(1));
    chk("squash_no_stale", 64'(commit_valid), 64'(0));

    // Flush at the committing head empties the buffer.
    alloc_set(1'b0, 1'b0, 1'b0); tick();
    alloc_set(1'b0, 1'b0, 1'b0); tick();
    cdb_set(0, 5, 32'h5A, 1'b0, 1'b1);
    tick();
    chk("fh_cvld", 64'(commit_valid), 64'(1));
    flush_valid  = 1'b1;
    flush_tag    = 5;
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("fh_count", 64'(count), 64'(0));
    chk("fh_atag", 64'(alloc_tag), 64'(6));
    void'(sb.pop_back());
    tail_m = 6;
    chk("fh_sb_empty", 64'(sb.size()), 64'(0));

    // Flush naming an invalid entry changes nothing.
    alloc_set(1'b0, 1'b0, 1'b0); tick();
    alloc_set(1'b0, 1'b0, 1'b0); tick();
    flush_valid = 1'b1;
    flush_tag   = 10;
    tick();
    chk("noop_flush_count", 64'(count), 64'(2));
    chk("noop_flush_atag", 64'(alloc_tag), 64'(8));

    // Store release and mispredicted branch.
    do_reset();
    alloc_set(1'b1, 1'b0, 1'b0); tick();
    alloc_set(1'b0, 1'b1, 1'b1); tick();
    chk("st_head_store", 64'(head_store), 64'(1));
    chk("st_cvld", 64'(commit_valid), 64'(0));
    cdb_set(1, 1, 32'h77, 1'b0, 1'b1);
    cdb_set(0, 0, 32'h66, 1'b0, 1'b1);
    tick();
    chk("st_ready_cvld", 64'(commit_valid), 64'(1));
    chk("st_is_store", 64'(commit_is_store), 64'(1));
    chk("st_no_mispred", 64'(commit_mispredict), 64'(0));
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("br_tag", 64'(commit_tag), 64'(1));
    chk("br_is_branch", 64'(commit_is_branch), 64'(1));
    chk("br_mispredict", 64'(commit_mispredict), 64'(1));
    chk("br_head_store", 64'(head_store), 64'(0));
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("final_empty", 64'(empty), 64'(1));
    chk("final_sb", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
